// File: rtl/mux2_stream_arb.sv
// rtl/mux2_stream_arb.sv - two-source valid/ready arbiter feeding a single registered output slot
// Optional MUX2_STREAM_ARB_PRIO_EN: in0 wins every tie instead of round-robin.
module mux2_stream_arb #(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in0_valid,
    input  logic [WIDTH-1:0] in0_data,
    output logic             in0_ready,
    input  logic             in1_valid,
    input  logic [WIDTH-1:0] in1_data,
    output logic             in1_ready,
    output logic             out_valid,
    output logic [WIDTH-1:0] out_data,
    output logic             out_sel,
    input  logic             out_ready
);

    typedef enum logic {
        EMPTY = 1'b0,
        FULL  = 1'b1
    } slot_state_e;

    slot_state_e      state_q, state_d;
    logic [WIDTH-1:0] data_q, data_d;
    logic             sel_q, sel_d;
    logic             last_grant_q, last_grant_d;

    logic accept;
    logic tie_grant;
    logic grant;
    logic xfer;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= EMPTY;
            data_q       <= '0;
            sel_q        <= 1'b0;
            last_grant_q <= 1'b1;
        end else begin
            state_q      <= state_d;
            data_q       <= data_d;
            sel_q        <= sel_d;
            last_grant_q <= last_grant_d;
        end
    end

    always_comb begin
        state_d      = state_q;
        data_d       = data_q;
        sel_d        = sel_q;
        last_grant_d = last_grant_q;
        in0_ready    = 1'b0;
        in1_ready    = 1'b0;

`ifdef MUX2_STREAM_ARB_PRIO_EN
        tie_grant = 1'b0;
`else
        tie_grant = ~last_grant_q;
`endif
        // Gating with rst_n keeps both readies low while reset is held.
        accept = rst_n && ((state_q == EMPTY) || out_ready);
        grant  = in1_valid && (!in0_valid || tie_grant);

        in0_ready = accept && in0_valid && !grant;
        in1_ready = accept && in1_valid && grant;
        xfer      = in0_ready || in1_ready;

        if (xfer) begin
            data_d       = grant ? in1_data : in0_data;
            sel_d        = grant;
            last_grant_d = grant;
            state_d      = FULL;
        end else if ((state_q == FULL) && out_ready) begin
            state_d = EMPTY;
        end
    end

    assign out_valid = (state_q == FULL);
    assign out_data  = data_q;
    assign out_sel   = sel_q;

endmodule
